// File: rtl/dram_dp_clr.sv
// -----------------------------------------------------------------------------
// dram_dp_clr
//
// Parametrised dual-port distributed RAM (DATA_W x 2**ADDR_W words) with a
// hardware clear sequencer and registered read outputs.
//
// After reset, or on a CLR pulse, the sequencer writes INIT_VAL to every word,
// one word per clock, holding BUSY high for exactly DEPTH cycles.
// User writes are dropped while BUSY is high.
// Port S (A) is read/write. Port D (DPRA) is read-only.
// Both ports have a combinational read and a registered read.
// DPO_Q is write-first on a same-address write. SPO_Q is read-old-value.
//
// Optional feature (macro DRAM_DP_PARITY_EN):
//   Each word carries one even-parity bit; ERR_INJ inverts it at write time.
//   PERR_S / PERR_D flag a mismatch on the registered reads.
//   Without the macro, PERR_S / PERR_D are constant 0 and ERR_INJ is ignored.
//
// Ports:
//   CLK      in   1       clock, everything on posedge
//   RST_N    in   1       asynchronous active-low reset
//   CLR      in   1       synchronous clear request (restarts the fill)
//   WE       in   1       write enable, ignored while BUSY
//   A        in   ADDR_W  read/write address, port S
//   DPRA     in   ADDR_W  read address, port D
//   D        in   DATA_W  write data
//   ERR_INJ  in   1       parity error injection (parity build only)
//   SPO      out  DATA_W  combinational mem[A]    (INIT_VAL while BUSY)
//   DPO      out  DATA_W  combinational mem[DPRA] (INIT_VAL while BUSY)
//   SPO_Q    out  DATA_W  registered SPO
//   DPO_Q    out  DATA_W  registered DPO with write-first bypass
//   BUSY     out  1       clear sequence in progress
//   PERR_S   out  1       registered parity error for SPO_Q
//   PERR_D   out  1       registered parity error for DPO_Q
// -----------------------------------------------------------------------------
module dram_dp_clr #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 7,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              WE,
   input  logic [ADDR_W-1:0] A,
   input  logic [ADDR_W-1:0] DPRA,
   input  logic [DATA_W-1:0] D,
   input  logic              ERR_INJ,
   output logic [DATA_W-1:0] SPO,
   output logic [DATA_W-1:0] DPO,
   output logic [DATA_W-1:0] SPO_Q,
   output logic [DATA_W-1:0] DPO_Q,
   output logic              BUSY,
   output logic              PERR_S,
   output logic              PERR_D
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              busy;
   logic              bypass;

   logic [DATA_W-1:0] mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational logic below uses blocking (=).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: defaults are assigned first so no path leaves an output unassigned,
   // which would infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_CLEAR: begin
            if (CLR) begin
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + ADDR_W'(1);
               // An all-ones count is the last word (DEPTH-1). cnt wraps to 0,
               // ready for the next fill.
               if (&cnt) state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (CLR) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

   assign busy = (state == ST_CLEAR);
   assign BUSY = busy;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset. It maps to LUT RAM, and the sequencer
   // defines its contents after reset instead.
   always_ff @(posedge CLK) begin
      if (busy)    mem[cnt] <= INIT_VAL;
      else if (WE) mem[A]   <= D;
   end

   assign SPO = busy ? INIT_VAL : mem[A];
   assign DPO = busy ? INIT_VAL : mem[DPRA];

   // Same-address write on this edge: port D sees the new data (write-first).
   assign bypass = WE && !busy && (DPRA == A);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SPO_Q <= '0;
         DPO_Q <= '0;
      end else begin
         SPO_Q <= SPO;
         DPO_Q <= bypass ? D : DPO;
      end
   end

`ifdef DRAM_DP_PARITY_EN
   // ---------------------------------------------------------------------------
   // Parity shadow: one bit per word, written alongside the data.
   // ---------------------------------------------------------------------------
   logic par_mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (busy)    par_mem[cnt] <= ^INIT_VAL;
      else if (WE) par_mem[A]   <= (^D) ^ ERR_INJ;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PERR_S <= 1'b0;
         PERR_D <= 1'b0;
      end else if (busy) begin
         PERR_S <= 1'b0;
         PERR_D <= 1'b0;
      end else begin
         PERR_S <= (^SPO) != par_mem[A];
         // On a bypass the stored bit is not visible yet. The word written
         // this edge is in error exactly when injection is requested.
         PERR_D <= bypass ? ERR_INJ : ((^DPO) != par_mem[DPRA]);
      end
   end
`else
   logic unused_err_inj;
   assign unused_err_inj = ERR_INJ;
   assign PERR_S         = 1'b0;
   assign PERR_D         = 1'b0;
`endif

endmodule

// File: tb/tb_dram_dp_clr.sv
// -----------------------------------------------------------------------------
// tb_dram_dp_clr
//
// Directed, self-checking bench for dram_dp_clr. The DUT runs with DATA_W=8,
// ADDR_W=7 and INIT_VAL=8'hA5, so a cleared word is distinguishable from a
// reset register (0).
// Parity expectations follow DRAM_DP_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_dram_dp_clr;

   localparam int unsigned       DATA_W = 8;
   localparam int unsigned       ADDR_W = 7;
   localparam logic [DATA_W-1:0] INIT   = 8'hA5;
`ifdef DRAM_DP_PARITY_EN
   localparam logic EXP_PAR = 1'b1;
`else
   localparam logic EXP_PAR = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              CLR;
   logic              WE;
   logic [ADDR_W-1:0] A;
   logic [ADDR_W-1:0] DPRA;
   logic [DATA_W-1:0] D;
   logic              ERR_INJ;
   logic [DATA_W-1:0] SPO;
   logic [DATA_W-1:0] DPO;
   logic [DATA_W-1:0] SPO_Q;
   logic [DATA_W-1:0] DPO_Q;
   logic              BUSY;
   logic              PERR_S;
   logic              PERR_D;

   int n_cmp = 0;
   int n_err = 0;
   int n;

   dram_dp_clr #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .INIT_VAL(INIT)
   ) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .CLR    (CLR),
      .WE     (WE),
      .A      (A),
      .DPRA   (DPRA),
      .D      (D),
      .ERR_INJ(ERR_INJ),
      .SPO    (SPO),
      .DPO    (DPO),
      .SPO_Q  (SPO_Q),
      .DPO_Q  (DPO_Q),
      .BUSY   (BUSY),
      .PERR_S (PERR_S),
      .PERR_D (PERR_D)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Count edges until BUSY drops, bounded so a stuck sequencer still ends.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (BUSY === 1'b1 && cycles < 400) begin
         step();
         cycles++;
      end
   endtask

   initial begin
      RST_N = 1'b0; CLR = 1'b0; WE = 1'b0; A = '0; DPRA = '0; D = '0; ERR_INJ = 1'b0;

      // Reset state, with the clock running.
      repeat (3) step();
      check("rst_busy",   BUSY,   1);
      check("rst_spo_q",  SPO_Q,  0);
      check("rst_dpo_q",  DPO_Q,  0);
      check("rst_perr_s", PERR_S, 0);
      check("rst_perr_d", PERR_D, 0);
      check("rst_spo_forced", SPO, INIT);

      // Initial fill after release.
      RST_N = 1'b1;
      wait_idle(n);
      check("fill_len", n, 128);
      A = 7'd0; DPRA = 7'd127; #1;
      check("fill_spo_0",   SPO, INIT);
      check("fill_dpo_127", DPO, INIT);
      step();
      check("fill_spo_q", SPO_Q, INIT);
      check("fill_dpo_q", DPO_Q, INIT);

      // Top-address write, read back on port D.
      WE = 1'b1; A = 7'd127; D = 8'h5A; DPRA = 7'd0;
      step();
      WE = 1'b0; DPRA = 7'd127; #1;
      check("wr_top_dpo", DPO, 8'h5A);

      // Write then CLR: the clear overwrites.
      WE = 1'b1; A = 7'd5; D = 8'h3C;
      step();
      WE = 1'b0; #1;
      check("wr5_spo", SPO, 8'h3C);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      check("clr_busy", BUSY, 1);
      wait_idle(n);
      check("clr_len", n, 128);
      #1;
      check("clr_spo_5",   SPO, INIT);
      check("clr_dpo_127", DPO, INIT);

      // Same-address write: DPO_Q write-first, SPO_Q read-old.
      A = 7'd9; DPRA = 7'd9; D = 8'h77; WE = 1'b1;
      step();
      WE = 1'b0;
      check("byp_dpo_q",     DPO_Q, 8'h77);
      check("byp_spo_q_old", SPO_Q, INIT);
      step();
      check("byp_spo_q_new", SPO_Q, 8'h77);
      check("byp_dpo_q_2",   DPO_Q, 8'h77);

      // Different addresses: no bypass.
      A = 7'd10; DPRA = 7'd9; D = 8'h11; WE = 1'b1;
      step();
      WE = 1'b0;
      check("nobyp_dpo_q", DPO_Q, 8'h77);
      check("nobyp_spo_q", SPO_Q, INIT);
      step();
      check("nobyp_spo_q_new", SPO_Q, 8'h11);

      // Writes while BUSY are dropped.
      CLR = 1'b1;
      step();
      CLR = 1'b0; WE = 1'b1; A = 7'd3; D = 8'hFF; DPRA = 7'd3;
      repeat (5) step();
      check("busy_spo",   SPO,   INIT);
      check("busy_spo_q", SPO_Q, INIT);
      check("busy_dpo_q", DPO_Q, INIT);
      WE = 1'b0;
      wait_idle(n);
      check("busy_rest_len", n, 123);
      #1;
      check("busy_drop_spo_3", SPO, INIT);
      A = 7'd9; #1;
      check("clr_spo_9", SPO, INIT);

      // Reset in the middle of a fill (cnt = 60).
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      repeat (60) step();
      RST_N = 1'b0; #1;
      check("midrst_busy",  BUSY,  1);
      check("midrst_spo_q", SPO_Q, 0);
      check("midrst_dpo_q", DPO_Q, 0);
      repeat (2) step();
      check("midrst_spo_q_hold", SPO_Q, 0);
      RST_N = 1'b1;
      wait_idle(n);
      check("midrst_len", n, 128);

      // Parity: injected error on port S.
      A = 7'd7; DPRA = 7'd8; D = 8'h12; WE = 1'b1; ERR_INJ = 1'b1;
      step();
      WE = 1'b0; ERR_INJ = 1'b0;
      check("par_spo_q_old", SPO_Q,  INIT);
      check("par_perr_s_old", PERR_S, 0);
      step();
      check("par_spo_q",  SPO_Q,  8'h12);
      check("par_perr_s", PERR_S, EXP_PAR);
      check("par_perr_d_clean", PERR_D, 0);

      // Parity: injected error seen through the bypass, then from the array.
      A = 7'd20; DPRA = 7'd20; D = 8'h12; WE = 1'b1; ERR_INJ = 1'b1;
      step();
      WE = 1'b0; ERR_INJ = 1'b0;
      check("par_byp_dpo_q",  DPO_Q,  8'h12);
      check("par_byp_perr_d", PERR_D, EXP_PAR);
      step();
      check("par_mem_perr_d", PERR_D, EXP_PAR);

      // Clean rewrite clears the error.
      A = 7'd7; DPRA = 7'd8; D = 8'h12; WE = 1'b1;
      step();
      WE = 1'b0;
      step();
      check("par_fix_perr_s", PERR_S, 0);
      check("par_fix_spo_q",  SPO_Q,  8'h12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
